// File: rtl/mul_unit_ctrl_if.sv
// ----------------------------------------------------------------------------
// mul_unit_ctrl_if
//   Bundles the three handshake/bus groups around the mul unit controller:
//     - issue request from the mul reservation station (req_*)
//     - operand/product path to the pipelined Dadda multiplier (mul_*)
//     - result towards the CDB (resp_*)
//   Modports:
//     slave  : the controller's view (consumes req, drives mul operands,
//              consumes product, drives resp)
//     master : the environment's view (RS, multiplier, CDB arbiter)
// ----------------------------------------------------------------------------
interface mul_unit_ctrl_if #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned ROB_IDX_W = 5,
   parameter int unsigned PREG_W    = 6
) ();
   logic                   req_valid;
   logic                   req_ready;
   logic [1:0]             req_op;
   logic [XLEN-1:0]        req_rs1;
   logic [XLEN-1:0]        req_rs2;
   logic [ROB_IDX_W-1:0]   req_rob_idx;
   logic [PREG_W-1:0]      req_pd;

   logic [XLEN-1:0]        mul_a;
   logic [XLEN-1:0]        mul_b;
   logic [2*XLEN-1:0]      mul_p;

   logic                   resp_valid;
   logic                   resp_ready;
   logic [XLEN-1:0]        resp_data;
   logic [ROB_IDX_W-1:0]   resp_rob_idx;
   logic [PREG_W-1:0]      resp_pd;

   modport slave (
      input  req_valid, req_op, req_rs1, req_rs2, req_rob_idx, req_pd,
      output req_ready,
      output mul_a, mul_b,
      input  mul_p,
      output resp_valid, resp_data, resp_rob_idx, resp_pd,
      input  resp_ready
   );

   modport master (
      output req_valid, req_op, req_rs1, req_rs2, req_rob_idx, req_pd,
      input  req_ready,
      input  mul_a, mul_b,
      output mul_p,
      input  resp_valid, resp_data, resp_rob_idx, resp_pd,
      output resp_ready
   );
endinterface

// File: rtl/mul_unit_ctrl.sv
// ----------------------------------------------------------------------------
// mul_unit_ctrl
//   Issue/completion controller for a non-stallable pipelined unsigned
//   XLEN x XLEN multiplier implementing RV32M MUL/MULH/MULHSU/MULHU.
//   Signed operands are converted to magnitudes on issue; ROB/preg tags and
//   the result sign travel in a sideband shift register aligned with the
//   multiplier pipeline; the sign fix-up is applied on exit and the result is
//   buffered in a FIFO towards the CDB. Credit-based issue guarantees the
//   FIFO never overflows under CDB backpressure.
// Ports:
//   clk_i    clock, all state on posedge
//   rst_ni   asynchronous active-low reset
//   flush_i  kill every in-flight and buffered op (same edge)
//   busy_o   any op in flight or buffered
//   bus      mul_unit_ctrl_if.slave: req_*, mul_*, resp_* groups
// ----------------------------------------------------------------------------
module mul_unit_ctrl #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned MUL_LATENCY = 8,
   parameter int unsigned ROB_IDX_W   = 5,
   parameter int unsigned PREG_W      = 6,
   parameter int unsigned OBUF_DEPTH  = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   output logic            busy_o,
   mul_unit_ctrl_if.slave  bus
);

   localparam int unsigned PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(OBUF_DEPTH + 1);
   localparam int unsigned OCC_W = $clog2(MUL_LATENCY + OBUF_DEPTH + 1);

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } op_e;

   typedef struct packed {
      logic                 v;
      op_e                  op;
      logic                 neg;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [PREG_W-1:0]    pd;
   } sb_t;

   typedef struct packed {
      logic [XLEN-1:0]      data;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [PREG_W-1:0]    pd;
   } res_t;

   op_e               req_op;
   logic              accept;
   logic              sign_a;
   logic              sign_b;

   sb_t               sb_q [MUL_LATENCY];
   sb_t               sb_d [MUL_LATENCY];
   sb_t               sb_exit;

   logic [2*XLEN-1:0] prod_fix;
   res_t              push_entry;
   res_t              head;
   logic              push;
   logic              pop;

   res_t              mem_q [OBUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [OCC_W-1:0]  occ;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // ---------------------------------------------------------------- issue
   assign req_op = op_e'(bus.req_op);
   assign accept = bus.req_valid & bus.req_ready & ~flush_i;

   always_comb begin
      sign_a    = (req_op != OP_MULHU) & bus.req_rs1[XLEN-1];
      sign_b    = ((req_op == OP_MUL) | (req_op == OP_MULH)) & bus.req_rs2[XLEN-1];
      bus.mul_a = '0;
      bus.mul_b = '0;
      if (accept) begin
         bus.mul_a = sign_a ? (~bus.req_rs1 + 1'b1) : bus.req_rs1;
         bus.mul_b = sign_b ? (~bus.req_rs2 + 1'b1) : bus.req_rs2;
      end
   end

   // ------------------------------------------------------------- sideband
   // Stage 0 captures every edge (v = accept) so its last stage lines up
   // with mul_p for the same operands; flush only needs to clear v bits.
   always_comb begin
      sb_d[0] = '{v: accept, op: req_op, neg: sign_a ^ sign_b,
                  rob_idx: bus.req_rob_idx, pd: bus.req_pd};
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
         sb_d[i] = sb_q[i-1];
         if (flush_i) begin
            sb_d[i].v = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
            sb_q[i] <= '0;
         end
      end else begin
         sb_q <= sb_d;
      end
   end

   // -------------------------------------------------------------- fix-up
   always_comb begin
      sb_exit            = sb_q[MUL_LATENCY-1];
      prod_fix           = sb_exit.neg ? (~bus.mul_p + 1'b1) : bus.mul_p;
      push_entry.data    = (sb_exit.op == OP_MUL) ? prod_fix[XLEN-1:0]
                                                  : prod_fix[2*XLEN-1:XLEN];
      push_entry.rob_idx = sb_exit.rob_idx;
      push_entry.pd      = sb_exit.pd;
      push               = sb_exit.v & ~flush_i;
      pop                = bus.resp_valid & bus.resp_ready;
   end

   // ---------------------------------------------------------- result FIFO
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while count_q != 0.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   always_comb begin
      head             = mem_q[rd_ptr_q];
      bus.resp_valid   = (count_q != '0);
      bus.resp_data    = bus.resp_valid ? head.data    : '0;
      bus.resp_rob_idx = bus.resp_valid ? head.rob_idx : '0;
      bus.resp_pd      = bus.resp_valid ? head.pd      : '0;
   end

   // -------------------------------------------------------------- credits
   // Occupancy is built from registered state only, so resp_ready never
   // reaches req_ready combinationally.
   always_comb begin
      occ = '0;
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
         occ = occ + OCC_W'(sb_q[i].v);
      end
      occ           = occ + OCC_W'(count_q);
      busy_o        = (occ != '0);
      bus.req_ready = rst_ni & (occ < OCC_W'(OBUF_DEPTH));
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && !pop && (count_q == CNT_W'(OBUF_DEPTH))));

endmodule

// File: tb/tb_mul_unit_ctrl.sv
module tb_mul_unit_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic busy;

   int n_cmp = 0;
   int n_bad = 0;
   int n_acc, n_pop, first_pop, last_pop, cyc, k;
   logic last_pop_busy;
   logic [42:0] exp_q [$];

   mul_unit_ctrl_if #(.XLEN(32), .ROB_IDX_W(5), .PREG_W(6)) bus ();

   mul_unit_ctrl #(
      .XLEN(32), .MUL_LATENCY(8), .ROB_IDX_W(5), .PREG_W(6), .OBUF_DEPTH(8)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .flush_i(flush),
      .busy_o (busy),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // 8-edge pipelined unsigned multiplier model
   logic [63:0] pipe [8];
   always_ff @(posedge clk) begin
      for (int i = 7; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= {32'b0, bus.mul_a} * {32'b0, bus.mul_b};
   end
   assign bus.mul_p = pipe[7];

   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (op == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
      eb = op[1] ? {32'b0, b} : {{32{b[31]}}, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rob, input logic [5:0] pd);
      bus.req_valid   = v;
      bus.req_op      = op;
      bus.req_rs1     = a;
      bus.req_rs2     = b;
      bus.req_rob_idx = rob;
      bus.req_pd      = pd;
   endtask

   // Called at a negedge; applies inputs for this cycle, scores a popped
   // response, records an accepted request, and returns at the next negedge.
   task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rob, input logic [5:0] pd,
                       input logic [31:0] expd, input logic rrdy);
      logic [42:0] e;
      drive(v, op, a, b, rob, pd);
      bus.resp_ready = rrdy;
      #1;
      if (bus.resp_valid && rrdy) begin
         if (exp_q.size() == 0) begin
            check("resp_unexpected_valid", 64'(bus.resp_valid), 64'h0);
         end else begin
            e = exp_q.pop_front();
            check("resp", 64'({bus.resp_data, bus.resp_rob_idx, bus.resp_pd}), 64'(e));
         end
         n_pop++;
         if (n_pop == 1) first_pop = cyc;
         last_pop      = cyc;
         last_pop_busy = busy;
      end
      if (v && bus.req_ready) begin
         exp_q.push_back({expd, rob, pd});
         n_acc++;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input logic rrdy);
      step(1'b0, 2'b00, 32'h0, 32'h0, 5'h0, 6'h0, 32'h0, rrdy);
   endtask

   task automatic drain(input string tag, input int max_cyc);
      int j;
      j = 0;
      while (exp_q.size() != 0 && j < max_cyc) begin
         idle(1'b1);
         j++;
      end
      check(tag, 64'(exp_q.size()), 64'h0);
   endtask

   initial begin : stim
      logic [1:0]  t2_op [4];
      logic [31:0] t2_a [4], t2_b [4], t2_r [4];
      logic [31:0] a, b;
      logic [1:0]  op;

      t2_op = '{2'b01, 2'b10, 2'b11, 2'b00};
      t2_a  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
      t2_b  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      t2_r  = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000};

      cyc = 0; n_acc = 0; n_pop = 0; first_pop = 0; last_pop = 0; last_pop_busy = 1'b0;
      rst_n = 1'b1;
      flush = 1'b0;
      bus.resp_ready = 1'b0;
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'h0, 6'h0);
      #1 rst_n = 1'b0;

      // ---- reset state
      repeat (2) @(negedge clk);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_req_ready", 64'(bus.req_ready), 64'h0);
      check("rst_resp_fields", 64'({bus.resp_data, bus.resp_rob_idx, bus.resp_pd}), 64'h0);
      rst_n = 1'b1;
      #1;
      check("rel_req_ready", 64'(bus.req_ready), 64'h1);

      // ---- 1: MUL 7 x -3, latency and tags
      bus.resp_ready = 1'b1;
      drive(1'b1, 2'b00, 32'd7, 32'hFFFFFFFD, 5'h0A, 6'h15);
      #1;
      check("t1_mul_a", 64'(bus.mul_a), 64'd7);
      check("t1_mul_b", 64'(bus.mul_b), 64'd3);
      @(negedge clk);
      drive(1'b0, 2'b00, 32'd7, 32'hFFFFFFFD, 5'h0A, 6'h15);
      #1;
      check("t1_mul_a_idle", 64'(bus.mul_a), 64'h0);
      check("t1_busy", 64'(busy), 64'h1);
      k = 1;
      while (!bus.resp_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("t1_latency", 64'(k), 64'd9);
      check("t1_resp", 64'({bus.resp_valid, bus.resp_data, bus.resp_rob_idx, bus.resp_pd}),
            64'({1'b1, 32'hFFFFFFEB, 5'h0A, 6'h15}));
      @(negedge clk);
      check("t1_resp_valid_after", 64'(bus.resp_valid), 64'h0);
      check("t1_busy_after", 64'(busy), 64'h0);

      // ---- 2: signedness corner cases
      for (int i = 0; i < 4; i++)
         step(1'b1, t2_op[i], t2_a[i], t2_b[i], 5'(16 + i), 6'(32 + i), t2_r[i], 1'b1);
      drain("t2_drain", 30);

      // ---- 3: backpressure fills exactly OBUF_DEPTH credits
      n_acc = 0;
      for (int i = 0; i < 16; i++) begin
         op = 2'(i % 4);
         a  = 32'hF0000001 + 32'(i);
         b  = 32'h00001234 << i;
         step(1'b1, op, a, b, 5'(n_acc), 6'(40 + n_acc), ref_mul(op, a, b), 1'b0);
      end
      check("t3_accepts", 64'(n_acc), 64'd8);
      check("t3_req_ready_low", 64'(bus.req_ready), 64'h0);
      check("t3_resp_valid_held", 64'(bus.resp_valid), 64'h1);
      n_pop = 0;
      drain("t3_drain", 30);
      check("t3_pops", 64'(n_pop), 64'd8);
      check("t3_pop_span", 64'(last_pop - first_pop), 64'd7);
      check("t3_req_ready_back", 64'(bus.req_ready), 64'h1);

      // ---- 4: sustained stream of 20 ops with CDB always granting
      n_acc = 0;
      k = 0;
      while (n_acc < 20 && k < 80) begin
         op = 2'(n_acc % 4);
         a  = 32'h9E3779B9 * 32'(n_acc + 1);
         b  = ~a ^ (32'h01010101 * 32'(n_acc));
         step(1'b1, op, a, b, 5'(n_acc), 6'(n_acc + 3), ref_mul(op, a, b), 1'b1);
         k++;
      end
      check("t4_accepts", 64'(n_acc), 64'd20);
      drain("t4_drain", 30);
      check("t4_busy_at_last_pop", 64'(last_pop_busy), 64'h1);
      check("t4_busy_after_last_pop", 64'(busy), 64'h0);

      // ---- 5: flush with 3 in flight + 2 buffered
      for (int i = 0; i < 5; i++)
         step(1'b1, 2'b11, 32'(i + 2), 32'd9, 5'(i), 6'(i), 32'h0, 1'b0);
      repeat (5) idle(1'b0);
      check("t5_pre_resp_valid", 64'(bus.resp_valid), 64'h1);
      flush = 1'b1;
      drive(1'b1, 2'b11, 32'd100, 32'd100, 5'h1F, 6'h3F);
      #1;
      check("t5_flush_mul_a", 64'(bus.mul_a), 64'h0);
      @(negedge clk);
      flush = 1'b0;
      exp_q.delete();
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'h0, 6'h0);
      #1;
      check("t5_resp_valid_post", 64'(bus.resp_valid), 64'h0);
      check("t5_req_ready_post", 64'(bus.req_ready), 64'h1);
      check("t5_busy_post", 64'(busy), 64'h0);
      n_pop = 0;
      repeat (15) idle(1'b1);
      check("t5_no_stale", 64'(n_pop), 64'h0);
      step(1'b1, 2'b11, 32'd5, 32'd3, 5'h07, 6'h2A, 32'h0, 1'b1);
      drain("t5_mulhu_drain", 30);

      // ---- 6: async reset mid-stream
      for (int i = 0; i < 4; i++)
         step(1'b1, 2'b00, 32'(i + 11), 32'd13, 5'(i), 6'(i), 32'(143 + 13 * i), 1'b1);
      repeat (2) idle(1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_resp_valid", 64'(bus.resp_valid), 64'h0);
      check("t6_rst_busy", 64'(busy), 64'h0);
      check("t6_rst_req_ready", 64'(bus.req_ready), 64'h0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("t6_rel_req_ready", 64'(bus.req_ready), 64'h1);
      n_pop = 0;
      repeat (15) idle(1'b1);
      check("t6_no_stale", 64'(n_pop), 64'h0);
      step(1'b1, 2'b00, 32'd6, 32'd7, 5'h03, 6'h09, 32'd42, 1'b1);
      drain("t6_mul_drain", 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
